tx_symbol_serializer_10b: RTL

Transmit-side parallel-to-serial stage that sits directly downstream of the 8b/10b encoder. It accepts 10-bit line-code symbols over a valid/ready handshake and shifts them out one bit per clock. When no symbol is offered at a symbol boundary, it inserts a configurable idle/comma symbol so the line never stalls. It also reports idle insertions and keeps a saturating underflow count for link bring-up debug.

---
 rtl/tx_symbol_serializer_10b.sv | 82 ++++++++
 1 files changed

// File: rtl/tx_symbol_serializer_10b.sv
// Parallel-to-serial stage for 10-bit line-code symbols, one bit per clock.
// Inserts IDLE_SYMBOL at empty symbol boundaries and counts underflows while running.
module tx_symbol_serializer_10b #(
    parameter logic [9:0] IDLE_SYMBOL = 10'b0011111010,
    parameter bit         MSB_FIRST   = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [9:0]  sym_i,
    input  logic        sym_valid_i,
    output logic        sym_ready_o,
    output logic        serial_o,
    output logic        sym_start_o,
    output logic        idle_insert_o,
    output logic [15:0] underflow_cnt_o
);

    localparam logic [0:0] StOff = 1'b0;
    localparam logic [0:0] StRun = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [9:0]  sh_q, sh_d;
    logic        start_q, start_d;
    logic        idle_q, idle_d;
    logic [15:0] underflow_cnt_q, underflow_cnt_d;

    assign sym_ready_o = enable_i & ((state_q == StOff) | (bit_cnt_q == 4'd9));

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        sh_d            = sh_q;
        start_d         = 1'b0;
        idle_d          = 1'b0;
        underflow_cnt_d = underflow_cnt_q;
        if (!enable_i) begin
            // Abort: the partial symbol is dropped and the line is held low.
            state_d   = StOff;
            bit_cnt_d = 4'd0;
            sh_d      = 10'd0;
        end else if (sym_ready_o) begin
            state_d   = StRun;
            bit_cnt_d = 4'd0;
            sh_d      = sym_valid_i ? sym_i : IDLE_SYMBOL;
            start_d   = 1'b1;
            idle_d    = ~sym_valid_i;
            // The first load out of OFF is not an underflow.
            if ((state_q == StRun) && !sym_valid_i && (underflow_cnt_q != 16'hFFFF)) begin
                underflow_cnt_d = underflow_cnt_q + 16'd1;
            end
        end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            sh_d      = MSB_FIRST ? {sh_q[8:0], 1'b0} : {1'b0, sh_q[9:1]};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= StOff;
            bit_cnt_q       <= 4'd0;
            sh_q            <= 10'd0;
            start_q         <= 1'b0;
            idle_q          <= 1'b0;
            underflow_cnt_q <= 16'd0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            sh_q            <= sh_d;
            start_q         <= start_d;
            idle_q          <= idle_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign serial_o        = MSB_FIRST ? sh_q[9] : sh_q[0];
    assign sym_start_o     = start_q;
    assign idle_insert_o   = idle_q;
    assign underflow_cnt_o = underflow_cnt_q;

endmodule
